// File: rtl/ad_pkg.sv
// Shared definitions for the AD7606 sample scheduler: FSM encoding, limits and
// the oversampling clamp.
package ad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV   = 2'd1,
        ST_WAIT   = 2'd2,
        ST_STREAM = 2'd3
    } ad_state_e;

    localparam logic [2:0] AD_OS_MAX     = 3'd6;
    localparam int         AD_NUM_CH_MAX = 8;

    function automatic logic [2:0] ad_clamp_os(input logic [2:0] req, input logic [2:0] max_code);
        return (req > max_code) ? max_code : req;
    endfunction

endpackage

// File: rtl/ad_period_timer.sv
// Programmable period timer: while running, counts 0..P-1 and flags the last count.
// P = max(period, 2), captured while stopped and again at every wrap.
module ad_period_timer #(
    parameter int PER_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_run,
    input  logic [PER_W-1:0] i_period,
    output logic             o_tick
);

    logic [PER_W-1:0] r_cnt;
    logic [PER_W-1:0] r_per;
    logic [PER_W-1:0] w_per_clamped;

    assign w_per_clamped = (i_period < PER_W'(2)) ? PER_W'(2) : i_period;
    assign o_tick        = i_run && (r_cnt == (r_per - PER_W'(1)));

    // Capturing the period while stopped makes the first tick land P cycles after run rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_per <= PER_W'(2);
        end else if (!i_run) begin
            r_cnt <= '0;
            r_per <= w_per_clamped;
        end else if (o_tick) begin
            r_cnt <= '0;
            r_per <= w_per_clamped;
        end else begin
            r_cnt <= r_cnt + PER_W'(1);
        end
    end

endmodule

// File: rtl/ad_sample_sched.sv
// AD7606 sample-rate scheduler: periodic/single conversion enable, frame snapshot on
// update, and a per-channel tagged word stream with sticky overrun/timeout status.
module ad_sample_sched
    import ad_pkg::*;
#(
    parameter int         NUM_CH  = 8,
    parameter int         PER_W   = 24,
    parameter int         TIMEOUT = 5000,
    parameter logic [2:0] OS_MAX  = AD_OS_MAX
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    input  logic                  single,
    input  logic [PER_W-1:0]      cfg_period,
    input  logic [2:0]            cfg_os,
    input  logic                  clr_err,
    output logic                  conv_en,
    output logic [2:0]            os,
    input  logic                  update,
    input  logic [16*NUM_CH-1:0]  ch_bus,
    output logic [15:0]           m_data,
    output logic [2:0]            m_ch,
    output logic                  m_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  sched_busy,
    output logic                  overrun,
    output logic                  timeout_err,
    output logic [7:0]            ovr_cnt,
    output logic [1:0]            dbg_state
);

    localparam logic [2:0] LAST_IDX  = 3'(NUM_CH - 1);
    localparam int         WCNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);

    ad_state_e         r_state;
    ad_state_e         w_state_nxt;
    logic              w_tick;
    logic              w_trig;
    logic              w_drop;
    logic              w_timeout;
    logic              w_hs;
    logic [WCNT_W-1:0] r_wcnt;
    logic [2:0]        r_idx;
    logic [2:0]        r_os;
    logic [15:0]       r_snap [AD_NUM_CH_MAX];
    logic              r_overrun;
    logic              r_timeout;
    logic [7:0]        r_ovr_cnt;

    ad_period_timer #(.PER_W(PER_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_run    (run),
        .i_period (cfg_period),
        .o_tick   (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_trig      = 1'b0;
        w_drop      = 1'b0;
        w_timeout   = 1'b0;
        w_hs        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_trig = w_tick | (single & ~run);
                if (w_trig) w_state_nxt = ST_CONV;
            end
            ST_CONV: begin
                w_drop      = w_tick;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                w_drop = w_tick;
                if (update) begin
                    w_state_nxt = ST_STREAM;
                end else if (r_wcnt == WCNT_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_STREAM: begin
                w_drop = w_tick;
                w_hs   = m_ready;
                if (w_hs && (r_idx == LAST_IDX)) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wcnt <= '0;
            r_idx  <= '0;
            r_os   <= '0;
            for (int k = 0; k < AD_NUM_CH_MAX; k++) r_snap[k] <= '0;
        end else begin
            // os only moves on an accepted trigger, so it is frozen for the whole frame.
            if (w_trig) r_os <= ad_clamp_os(cfg_os, OS_MAX);
            if (r_state == ST_CONV)      r_wcnt <= '0;
            else if (r_state == ST_WAIT) r_wcnt <= r_wcnt + WCNT_W'(1);
            if ((r_state == ST_WAIT) && update) begin
                for (int k = 0; k < NUM_CH; k++) r_snap[k] <= ch_bus[16*k +: 16];
            end
            if (w_hs) r_idx <= (r_idx == LAST_IDX) ? 3'd0 : r_idx + 3'd1;
        end
    end

    // Set events beat a simultaneous clr_err; the counter restarts at 1 in that case.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
            r_timeout <= 1'b0;
            r_ovr_cnt <= '0;
        end else begin
            r_overrun <= w_drop    | (r_overrun & ~clr_err);
            r_timeout <= w_timeout | (r_timeout & ~clr_err);
            if (clr_err)                           r_ovr_cnt <= w_drop ? 8'd1 : 8'd0;
            else if (w_drop && r_ovr_cnt != 8'hFF) r_ovr_cnt <= r_ovr_cnt + 8'd1;
        end
    end

    // Stream: a word transfers on a cycle with m_valid & m_ready; while m_valid is
    // high and m_ready low, m_data/m_ch/m_last hold their value.
    assign m_valid     = (r_state == ST_STREAM);
    assign m_data      = m_valid ? r_snap[r_idx] : 16'd0;
    assign m_ch        = r_idx;
    assign m_last      = m_valid && (r_idx == LAST_IDX);
    assign conv_en     = (r_state == ST_CONV);
    assign os          = r_os;
    assign sched_busy  = (r_state != ST_IDLE);
    assign overrun     = r_overrun;
    assign timeout_err = r_timeout;
    assign ovr_cnt     = r_ovr_cnt;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_ad_sample_sched.sv
// Directed bench for ad_sample_sched: one task per scenario, inline comparisons,
// single summary line at the end.
module tb_ad_sample_sched;
    import ad_pkg::*;

    localparam int TIMEOUT = 5000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          run;
    logic          single;
    logic [23:0]   cfg_period;
    logic [2:0]    cfg_os;
    logic          clr_err;
    logic          conv_en;
    logic [2:0]    os;
    logic          update;
    logic [127:0]  ch_bus;
    logic [15:0]   m_data;
    logic [2:0]    m_ch;
    logic          m_last;
    logic          m_valid;
    logic          m_ready;
    logic          sched_busy;
    logic          overrun;
    logic          timeout_err;
    logic [7:0]    ovr_cnt;
    logic [1:0]    dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    ad_sample_sched dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .single      (single),
        .cfg_period  (cfg_period),
        .cfg_os      (cfg_os),
        .clr_err     (clr_err),
        .conv_en     (conv_en),
        .os          (os),
        .update      (update),
        .ch_bus      (ch_bus),
        .m_data      (m_data),
        .m_ch        (m_ch),
        .m_last      (m_last),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .sched_busy  (sched_busy),
        .overrun     (overrun),
        .timeout_err (timeout_err),
        .ovr_cnt     (ovr_cnt),
        .dbg_state   (dbg_state)
    );

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_single();
        step(); single = 1'b1;
        step(); single = 1'b0;
    endtask

    task automatic pulse_clr();
        step(); clr_err = 1'b1;
        step(); clr_err = 1'b0;
    endtask

    task automatic wait_conv_en(input int budget, output int at_cyc);
        bit found;
        found  = 1'b0;
        at_cyc = -1;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (conv_en === 1'b1) begin
                found  = 1'b1;
                at_cyc = cyc_cnt;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL conv_en_wait: got no conv_en in %0d cycles, want one", budget);
        end
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && sched_busy !== 1'b0; i++) @(negedge clk);
        checks++;
        if (sched_busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_wait: got sched_busy=%b after %0d cycles, want 0", sched_busy, budget);
        end
    endtask

    task automatic send_update(input int delay, input logic [127:0] bus);
        repeat (delay) @(posedge clk);
        #1;
        ch_bus = bus;
        update = 1'b1;
        step();
        update = 1'b0;
    endtask

    // Scoreboard for one frame; entered at the first STREAM cycle.
    task automatic collect_frame(input bit rnd_ready, input logic [127:0] bus);
        logic [15:0] exp_q[$];
        logic [2:0]  exp_ch;
        int          guard;
        exp_q = {};
        for (int k = 0; k < 8; k++) exp_q.push_back(bus[16*k +: 16]);
        exp_ch = 3'd0;
        guard  = 0;
        while (exp_q.size() > 0 && guard < 200) begin
            m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            checks++;
            if (m_valid !== 1'b1 || m_ch !== exp_ch || m_data !== exp_q[0] || m_last !== (exp_ch == 3'd7)) begin
                errors++;
                $display("FAIL stream_word: got valid=%b ch=%0d data=%h last=%b, want valid=1 ch=%0d data=%h last=%b",
                         m_valid, m_ch, m_data, m_last, exp_ch, exp_q[0], (exp_ch == 3'd7));
            end
            if (m_valid === 1'b1 && m_ready) begin
                void'(exp_q.pop_front());
                exp_ch = exp_ch + 3'd1;
            end
            step();
            guard++;
        end
        m_ready = 1'b1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL stream_count: got %0d words left, want 0", exp_q.size());
        end
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0 || m_last !== 1'b0) begin
            errors++;
            $display("FAIL stream_end: got valid=%b last=%b, want 0 0", m_valid, m_last);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({conv_en, os, m_data, m_ch, m_last, m_valid, sched_busy, overrun, timeout_err, ovr_cnt} !== '0
            || dbg_state !== 2'(ST_IDLE)) begin
            errors++;
            $display("FAIL reset_outputs: got conv_en=%b os=%0d data=%h ch=%0d last=%b valid=%b busy=%b ovr=%b to=%b cnt=%0d state=%0d, want all 0",
                     conv_en, os, m_data, m_ch, m_last, m_valid, sched_busy, overrun, timeout_err, ovr_cnt, dbg_state);
        end
        step();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (sched_busy !== 1'b0 || conv_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got busy=%b conv_en=%b, want 0 0", sched_busy, conv_en);
        end
    endtask

    task automatic test_periodic();
        int t0;
        int t1;
        logic [127:0] bus;
        cfg_period = 24'd100;
        m_ready    = 1'b1;
        step();
        run = 1'b1;
        t0  = cyc_cnt;
        for (int f = 0; f < 3; f++) begin
            wait_conv_en(300, t1);
            checks++;
            if (t1 - t0 != 100) begin
                errors++;
                $display("FAIL conv_period f=%0d: got %0d cycles, want 100", f, t1 - t0);
            end
            t0 = t1;
            for (int k = 0; k < 8; k++) bus[16*k +: 16] = 16'hA000 + 16'(f * 16 + k);
            send_update(40, bus);
            collect_frame(1'b0, bus);
        end
        step();
        run = 1'b0;
        checks++;
        if (overrun !== 1'b0 || ovr_cnt !== 8'd0) begin
            errors++;
            $display("FAIL periodic_no_overrun: got overrun=%b cnt=%0d, want 0 0", overrun, ovr_cnt);
        end
    endtask

    task automatic test_fast_tick();
        int t0;
        int t1;
        cfg_period = 24'd1;
        step();
        run = 1'b1;
        t0  = cyc_cnt;
        wait_conv_en(20, t1);
        checks++;
        if (t1 - t0 != 2) begin
            errors++;
            $display("FAIL period1_first: got %0d cycles, want 2", t1 - t0);
        end
        step(); step();
        @(negedge clk);
        checks++;
        if (ovr_cnt !== 8'd1 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_first: got cnt=%0d overrun=%b, want 1 1", ovr_cnt, overrun);
        end
        step(); step();
        @(negedge clk);
        checks++;
        if (ovr_cnt !== 8'd2) begin
            errors++;
            $display("FAIL overrun_second: got cnt=%0d, want 2", ovr_cnt);
        end
        step();
        clr_err = 1'b1;
        step();
        @(negedge clk);
        checks++;
        if (ovr_cnt !== 8'd1 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL clr_vs_set: got cnt=%0d overrun=%b, want 1 1", ovr_cnt, overrun);
        end
        step();
        clr_err = 1'b0;
        @(negedge clk);
        checks++;
        if (ovr_cnt !== 8'd0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL clr_only: got cnt=%0d overrun=%b, want 0 0", ovr_cnt, overrun);
        end
        step();
        run = 1'b0;
        wait_idle(TIMEOUT + 100);

        cfg_period = 24'd0;
        step();
        run = 1'b1;
        t0  = cyc_cnt;
        wait_conv_en(20, t1);
        checks++;
        if (t1 - t0 != 2) begin
            errors++;
            $display("FAIL period0_first: got %0d cycles, want 2", t1 - t0);
        end
        for (int i = 0; i < 1000 && ovr_cnt !== 8'd255; i++) @(negedge clk);
        checks++;
        if (ovr_cnt !== 8'd255) begin
            errors++;
            $display("FAIL ovr_saturate: got cnt=%0d, want 255", ovr_cnt);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (ovr_cnt !== 8'd255 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_hold: got cnt=%0d overrun=%b, want 255 1", ovr_cnt, overrun);
        end
        step();
        run = 1'b0;
        wait_idle(TIMEOUT + 100);
        pulse_clr();
        @(negedge clk);
        checks++;
        if (overrun !== 1'b0 || timeout_err !== 1'b0 || ovr_cnt !== 8'd0) begin
            errors++;
            $display("FAIL flags_cleared: got overrun=%b to=%b cnt=%0d, want 0 0 0", overrun, timeout_err, ovr_cnt);
        end
    endtask

    task automatic test_timeout();
        int  t1;
        bit  saw_valid;
        logic [127:0] bus;
        step(); update = 1'b1;
        step(); update = 1'b0;
        @(negedge clk);
        checks++;
        if (sched_busy !== 1'b0 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL update_in_idle: got busy=%b valid=%b, want 0 0", sched_busy, m_valid);
        end
        pulse_single();
        wait_conv_en(5, t1);
        saw_valid = 1'b0;
        for (int i = 0; i < TIMEOUT; i++) begin
            @(negedge clk);
            if (m_valid !== 1'b0) saw_valid = 1'b1;
        end
        checks++;
        if (timeout_err !== 1'b0 || sched_busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_early: got to=%b busy=%b, want 0 1", timeout_err, sched_busy);
        end
        @(negedge clk);
        checks++;
        if (timeout_err !== 1'b1 || sched_busy !== 1'b0 || saw_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_hit: got to=%b busy=%b saw_valid=%b, want 1 0 0", timeout_err, sched_busy, saw_valid);
        end
        cfg_period = 24'd50;
        step();
        run = 1'b1;
        wait_conv_en(100, t1);
        for (int k = 0; k < 8; k++) bus[16*k +: 16] = 16'h5A00 + 16'(k * 3);
        send_update(5, bus);
        collect_frame(1'b0, bus);
        step();
        run = 1'b0;
        checks++;
        if (timeout_err !== 1'b1 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL timeout_sticky: got to=%b overrun=%b, want 1 0", timeout_err, overrun);
        end
        pulse_clr();
        @(negedge clk);
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clear: got to=%b, want 0", timeout_err);
        end
    endtask

    task automatic test_backpressure();
        int t1;
        logic [127:0] bus;
        for (int k = 0; k < 8; k++) bus[16*k +: 16] = 16'h1111 * 16'(k + 1);
        pulse_single();
        wait_conv_en(5, t1);
        send_update(3, bus);
        collect_frame(1'b1, bus);
        for (int k = 0; k < 8; k++) bus[16*k +: 16] = ~(16'h1111 * 16'(k + 1));
        pulse_single();
        wait_conv_en(5, t1);
        send_update(7, bus);
        collect_frame(1'b1, bus);
    endtask

    task automatic test_os();
        int t1;
        logic [127:0] bus;
        for (int k = 0; k < 8; k++) bus[16*k +: 16] = 16'h0C00 + 16'(k);
        cfg_os = 3'd7;
        pulse_single();
        wait_conv_en(5, t1);
        checks++;
        if (os !== 3'd6) begin
            errors++;
            $display("FAIL os_clamp: got os=%0d, want 6", os);
        end
        @(negedge clk);
        checks++;
        if (conv_en !== 1'b0) begin
            errors++;
            $display("FAIL conv_en_width: got conv_en=%b one cycle later, want 0", conv_en);
        end
        step();
        cfg_os = 3'd3;
        single = 1'b1;
        step();
        single = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (os !== 3'd6 || overrun !== 1'b0 || sched_busy !== 1'b1) begin
            errors++;
            $display("FAIL os_hold_wait: got os=%0d overrun=%b busy=%b, want 6 0 1", os, overrun, sched_busy);
        end
        send_update(2, bus);
        collect_frame(1'b0, bus);
        @(negedge clk);
        checks++;
        if (os !== 3'd6 || sched_busy !== 1'b0) begin
            errors++;
            $display("FAIL os_hold_idle: got os=%0d busy=%b, want 6 0", os, sched_busy);
        end
        pulse_single();
        wait_conv_en(5, t1);
        checks++;
        if (os !== 3'd3) begin
            errors++;
            $display("FAIL os_next_frame: got os=%0d, want 3", os);
        end
        send_update(2, bus);
        collect_frame(1'b0, bus);
    endtask

    task automatic test_reset_mid_frame();
        int t1;
        logic [127:0] bus;
        for (int k = 0; k < 8; k++) bus[16*k +: 16] = 16'hBEE0 + 16'(k);
        cfg_os = 3'd5;
        pulse_single();
        wait_conv_en(5, t1);
        send_update(2, bus);
        m_ready = 1'b1;
        step(); step(); step();
        m_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b1 || m_ch !== 3'd3 || m_data !== 16'hBEE3) begin
            errors++;
            $display("FAIL pre_reset_idx: got valid=%b ch=%0d data=%h, want 1 3 bee3", m_valid, m_ch, m_data);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({conv_en, os, m_data, m_ch, m_last, m_valid, sched_busy, overrun, timeout_err, ovr_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_mid_frame: got conv_en=%b os=%0d data=%h ch=%0d last=%b valid=%b busy=%b, want all 0",
                     conv_en, os, m_data, m_ch, m_last, m_valid, sched_busy);
        end
        step(); step();
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) bus[16*k +: 16] = 16'h7700 + 16'(k * 17);
        pulse_single();
        wait_conv_en(5, t1);
        checks++;
        if (os !== 3'd5) begin
            errors++;
            $display("FAIL os_after_reset: got os=%0d, want 5", os);
        end
        send_update(2, bus);
        collect_frame(1'b0, bus);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst_n      = 1'b0;
        run        = 1'b0;
        single     = 1'b0;
        cfg_period = 24'd100;
        cfg_os     = 3'd0;
        clr_err    = 1'b0;
        update     = 1'b0;
        ch_bus     = '0;
        m_ready    = 1'b1;
        test_reset();
        test_periodic();
        test_fast_tick();
        test_timeout();
        test_backpressure();
        test_os();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
